tube_scheduler: RTL and testbench

- Game-level sequencer for the scrolling tubes in the VGA game.
- Owns N_TUBES tube slots, each with an x position, a gap height and an active flag.
- Spawns a new tube at the right screen edge when the newest tube reaches the spawn threshold, and moves all tubes one step per frame tick.
- Reports passed-tube score pulses and freezes on collision; sits between the frame-tick generator/LFSR and the pixel renderer.

---
 rtl/tube_scheduler_pkg.sv | 25 ++
 rtl/tube_scheduler_slot.sv | 49 ++++
 rtl/tube_scheduler.sv | 129 ++++++++++++
 tb/tb_tube_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tube_scheduler_pkg.sv
// Shared definitions for the tube scheduler: FSM encoding, screen geometry,
// default placement constants and the gap-height helper.
package tube_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    SPAWN   = 3'd2,
    RUN     = 3'd3,
    STOPPED = 3'd4
  } state_t;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int DEF_SPAWN_X  = 639;
  localparam int DEF_SPAWN_AT = 320;
  localparam int DEF_BIRD_X   = 160;
  localparam int DEF_GAP_MIN  = 64;

  // Gap top = minimum gap plus zero-extended random byte (max 64+255 = 319).
  function automatic logic [8:0] gap_from_rand(input logic [8:0] gmin, input logic [7:0] r);
    return gmin + {1'b0, r};
  endfunction

endpackage

// File: rtl/tube_scheduler_slot.sv
// One tube slot: holds x position, gap height and active flag, moves left
// on request and flags the move that carries it across the bird column.
module tube_slot
  import tube_scheduler_pkg::*;
#(
  parameter int SPAWN_X = DEF_SPAWN_X,
  parameter int BIRD_X  = DEF_BIRD_X,
  parameter int STEP    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [8:0] load_gap,
  input  logic       move,
  output logic [9:0] posx,
  output logic [8:0] gap_y,
  output logic       active,
  output logic       crossed_bird
);

  logic       under;
  logic [9:0] posx_nx;

  // Saturate at the left edge: a tube closer than one step leaves the screen.
  assign under        = posx < 10'(STEP);
  assign posx_nx      = under ? '0 : posx - 10'(STEP);
  assign crossed_bird = move & active & (posx >= 10'(BIRD_X)) & (posx_nx < 10'(BIRD_X));

  // Slot state: clear wins over load, load wins over move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      posx   <= '0;
      gap_y  <= '0;
      active <= 1'b0;
    end else if (clear) begin
      posx   <= '0;
      active <= 1'b0;
    end else if (load) begin
      posx   <= 10'(SPAWN_X);
      gap_y  <= load_gap;
      active <= 1'b1;
    end else if (move && active) begin
      posx <= posx_nx;
      if (under) active <= 1'b0;
    end
  end

endmodule

// File: rtl/tube_scheduler.sv
// Game-level tube sequencer: FSM, newest-slot pointer, deferred spawn and
// score pulse, driving an array of tube_slot instances.
module tube_scheduler
  import tube_scheduler_pkg::*;
#(
  parameter int N_TUBES  = 3,
  parameter int SPAWN_X  = DEF_SPAWN_X,
  parameter int SPAWN_AT = DEF_SPAWN_AT,
  parameter int BIRD_X   = DEF_BIRD_X,
  parameter int STEP     = 1,
  parameter int GAP_MIN  = DEF_GAP_MIN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inicio,
  input  logic                   pause,
  input  logic                   frame_tick,
  input  logic                   collision,
  input  logic [7:0]             rand_in,
  output logic                   rand_req,
  output logic [10*N_TUBES-1:0]  posx,
  output logic [9*N_TUBES-1:0]   gap_y,
  output logic [N_TUBES-1:0]     active,
  output logic                   score_pulse,
  output logic                   running,
  output logic                   game_over
);

  localparam int PW = (N_TUBES > 2) ? 2 : 1;

  state_t state, state_n;

  logic [N_TUBES-1:0][9:0] px;
  logic [N_TUBES-1:0][8:0] gy;
  logic [N_TUBES-1:0]      act, crossed, ld;
  logic [PW-1:0]           newest, slot_s;
  logic                    spawn_pending;
  logic                    tick, do_clear, do_load, do_move, set_pend, req_new, req_pend;
  logic [8:0]              gap_new;

  assign posx    = px;
  assign gap_y   = gy;
  assign active  = act;
  assign slot_s  = (newest == PW'(N_TUBES-1)) ? '0 : newest + 1'b1;
  assign gap_new = gap_from_rand(9'(GAP_MIN), rand_in);
  assign ld      = do_load ? (N_TUBES'(1) << slot_s) : '0;
  assign tick    = frame_tick & ~pause;

  // Newest tube lands on SPAWN_AT this tick (checked before the move).
  assign req_new  = tick & act[newest] & (px[newest] == 10'(SPAWN_AT + STEP));
  // Deferred spawn: the blocking slot is free now, or leaves on this tick.
  assign req_pend = spawn_pending & (~act[slot_s] | (tick & (px[slot_s] < 10'(STEP))));

  generate
    for (genvar i = 0; i < N_TUBES; i++) begin : g_slot
      tube_slot #(.SPAWN_X(SPAWN_X), .BIRD_X(BIRD_X), .STEP(STEP)) u_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (do_clear),
        .load         (ld[i]),
        .load_gap     (gap_new),
        .move         (do_move),
        .posx         (px[i]),
        .gap_y        (gy[i]),
        .active       (act[i]),
        .crossed_bird (crossed[i])
      );
    end
  endgenerate

  // Next state and per-cycle slot controls; collision outranks a tick.
  always_comb begin
    state_n  = state;
    do_clear = 1'b0;
    do_load  = 1'b0;
    do_move  = 1'b0;
    set_pend = 1'b0;
    case (state)
      IDLE:    if (inicio) state_n = CLEAR;
      CLEAR: begin
        do_clear = 1'b1;
        state_n  = SPAWN;
      end
      SPAWN: begin
        if (!act[slot_s]) do_load  = 1'b1;
        else              set_pend = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        if (collision) state_n = STOPPED;
        else begin
          do_move = tick;
          if (req_new || req_pend) state_n = SPAWN;
        end
      end
      STOPPED: if (inicio) state_n = CLEAR;
      default: state_n = IDLE;
    endcase
  end

  // State, pointer, pending flag and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      newest        <= '0;
      spawn_pending <= 1'b0;
      rand_req      <= 1'b0;
      score_pulse   <= 1'b0;
      running       <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state       <= state_n;
      rand_req    <= do_load;
      score_pulse <= do_move & (|crossed);
      running     <= (state_n == RUN);
      game_over   <= (state_n == STOPPED);
      if (do_clear) begin
        newest        <= PW'(N_TUBES-1);
        spawn_pending <= 1'b0;
      end else if (do_load) begin
        newest        <= slot_s;
        spawn_pending <= 1'b0;
      end else if (set_pend) begin
        spawn_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tube_scheduler.sv
// Directed bench: default 3-slot scheduler (A) plus a 2-slot instance (B)
// with a near-edge spawn threshold that forces the all-slots-busy path.
module tb_tube_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_inicio = 0, a_pause = 0, a_tick = 0, a_coll = 0;
  logic [7:0]  a_rand = 0;
  logic        a_rr, a_sp, a_run, a_go;
  logic [29:0] a_posx;
  logic [26:0] a_gap;
  logic [2:0]  a_act;
  logic [2:0][9:0] a_px;
  logic [2:0][8:0] a_gy;
  assign a_px = a_posx;
  assign a_gy = a_gap;

  logic        b_inicio = 0, b_pause = 0, b_tick = 0, b_coll = 0;
  logic [7:0]  b_rand = 0;
  logic        b_rr, b_sp, b_run, b_go;
  logic [19:0] b_posx;
  logic [17:0] b_gap;
  logic [1:0]  b_act;
  logic [1:0][9:0] b_px;
  logic [1:0][8:0] b_gy;
  assign b_px = b_posx;
  assign b_gy = b_gap;

  tube_scheduler u_a (
    .clk(clk), .rst_n(rst_n), .inicio(a_inicio), .pause(a_pause),
    .frame_tick(a_tick), .collision(a_coll), .rand_in(a_rand),
    .rand_req(a_rr), .posx(a_posx), .gap_y(a_gap), .active(a_act),
    .score_pulse(a_sp), .running(a_run), .game_over(a_go)
  );

  tube_scheduler #(.N_TUBES(2), .SPAWN_AT(600)) u_b (
    .clk(clk), .rst_n(rst_n), .inicio(b_inicio), .pause(b_pause),
    .frame_tick(b_tick), .collision(b_coll), .rand_in(b_rand),
    .rand_req(b_rr), .posx(b_posx), .gap_y(b_gap), .active(b_act),
    .score_pulse(b_sp), .running(b_run), .game_over(b_go)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int a_score_cnt = 0;

  always @(posedge clk) if (a_sp === 1'b1) a_score_cnt++;

  task automatic a_ticks(input int n);
    repeat (n) begin
      a_tick = 1; @(negedge clk);
      a_tick = 0; @(negedge clk);
    end
  endtask

  task automatic b_ticks(input int n);
    repeat (n) begin
      b_tick = 1; @(negedge clk);
      b_tick = 0; @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total_cnt++; if ({a_rr, a_sp, a_run, a_go} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {a_rr, a_sp, a_run, a_go}); else pass_cnt++;
    total_cnt++; if (a_act !== 3'b000) $display("FAIL reset_active got %b want 000", a_act); else pass_cnt++;
    total_cnt++; if (a_posx !== 30'd0 || a_gap !== 27'd0) $display("FAIL reset_pos got %h/%h want 0/0", a_posx, a_gap); else pass_cnt++;
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_start;
    a_rand = 8'd10; a_inicio = 1; @(negedge clk); a_inicio = 0;
    total_cnt++; if (a_act !== 3'b000 || a_run !== 1'b0) $display("FAIL start_clear got act=%b run=%b want 000/0", a_act, a_run); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_act !== 3'b000) $display("FAIL start_spawn_cycle got %b want 000", a_act); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_act !== 3'b001) $display("FAIL start_active got %b want 001", a_act); else pass_cnt++;
    total_cnt++; if (a_px[0] !== 10'd639) $display("FAIL start_posx got %0d want 639", a_px[0]); else pass_cnt++;
    total_cnt++; if (a_gy[0] !== 9'd74) $display("FAIL start_gap got %0d want 74", a_gy[0]); else pass_cnt++;
    total_cnt++; if (a_rr !== 1'b1 || a_run !== 1'b1) $display("FAIL start_rr_run got %b%b want 11", a_rr, a_run); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_rr !== 1'b0) $display("FAIL start_rr_pulse got %b want 0", a_rr); else pass_cnt++;
  endtask

  task automatic test_scroll;
    a_rand = 8'd255;
    a_ticks(318);
    a_tick = 1; @(negedge clk); a_tick = 0;
    total_cnt++; if (a_px[0] !== 10'd320 || a_act !== 3'b001) $display("FAIL scroll_at_threshold got x=%0d act=%b want 320/001", a_px[0], a_act); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_act !== 3'b011 || a_px[1] !== 10'd639) $display("FAIL scroll_spawn got act=%b x1=%0d want 011/639", a_act, a_px[1]); else pass_cnt++;
    total_cnt++; if (a_gy[1] !== 9'd319 || a_rr !== 1'b1) $display("FAIL scroll_gap_max got gap=%0d rr=%b want 319/1", a_gy[1], a_rr); else pass_cnt++;
    total_cnt++; if (a_px[0] !== 10'd320) $display("FAIL scroll_hold_in_spawn got %0d want 320", a_px[0]); else pass_cnt++;
  endtask

  task automatic test_score;
    a_ticks(160);
    total_cnt++; if (a_px[0] !== 10'd160 || a_score_cnt !== 0) $display("FAIL score_before got x=%0d cnt=%0d want 160/0", a_px[0], a_score_cnt); else pass_cnt++;
    a_tick = 1; @(negedge clk); a_tick = 0;
    total_cnt++; if (a_sp !== 1'b1 || a_px[0] !== 10'd159) $display("FAIL score_pulse got sp=%b x=%0d want 1/159", a_sp, a_px[0]); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_sp !== 1'b0) $display("FAIL score_one_cycle got %b want 0", a_sp); else pass_cnt++;
    a_rand = 8'd7;
    a_ticks(159);
    total_cnt++; if (a_px[0] !== 10'd0 || a_act !== 3'b111) $display("FAIL score_edge got x=%0d act=%b want 0/111", a_px[0], a_act); else pass_cnt++;
    total_cnt++; if (a_px[2] !== 10'd638 || a_gy[2] !== 9'd71) $display("FAIL score_third got x=%0d gap=%0d want 638/71", a_px[2], a_gy[2]); else pass_cnt++;
    a_ticks(1);
    total_cnt++; if (a_act !== 3'b110 || a_px[0] !== 10'd0) $display("FAIL score_deactivate got act=%b x=%0d want 110/0", a_act, a_px[0]); else pass_cnt++;
    total_cnt++; if (a_px[1] !== 10'd318 || a_px[2] !== 10'd637) $display("FAIL score_others got %0d/%0d want 318/637", a_px[1], a_px[2]); else pass_cnt++;
    total_cnt++; if (a_score_cnt !== 1) $display("FAIL score_count got %0d want 1", a_score_cnt); else pass_cnt++;
  endtask

  task automatic test_collision;
    a_tick = 1; a_coll = 1; @(negedge clk); a_tick = 0; a_coll = 0;
    total_cnt++; if (a_go !== 1'b1 || a_run !== 1'b0) $display("FAIL coll_flags got go=%b run=%b want 1/0", a_go, a_run); else pass_cnt++;
    total_cnt++; if (a_px[1] !== 10'd318 || a_sp !== 1'b0) $display("FAIL coll_no_move got x=%0d sp=%b want 318/0", a_px[1], a_sp); else pass_cnt++;
    a_ticks(3);
    total_cnt++; if (a_px[1] !== 10'd318 || a_act !== 3'b110 || a_go !== 1'b1) $display("FAIL coll_frozen got x=%0d act=%b go=%b want 318/110/1", a_px[1], a_act, a_go); else pass_cnt++;
    a_rand = 8'd0; a_inicio = 1; @(negedge clk); a_inicio = 0;
    total_cnt++; if (a_go !== 1'b0) $display("FAIL restart_go got %b want 0", a_go); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_act !== 3'b000 || a_posx !== 30'd0) $display("FAIL restart_clear got act=%b posx=%h want 000/0", a_act, a_posx); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_act !== 3'b001 || a_px[0] !== 10'd639 || a_gy[0] !== 9'd64 || a_run !== 1'b1) $display("FAIL restart_spawn got act=%b x=%0d gap=%0d run=%b want 001/639/64/1", a_act, a_px[0], a_gy[0], a_run); else pass_cnt++;
  endtask

  task automatic test_pause;
    a_pause = 1;
    a_ticks(50);
    total_cnt++; if (a_px[0] !== 10'd639 || a_run !== 1'b1) $display("FAIL pause_hold got x=%0d run=%b want 639/1", a_px[0], a_run); else pass_cnt++;
    a_pause = 0;
    a_ticks(1);
    total_cnt++; if (a_px[0] !== 10'd638) $display("FAIL pause_resume got %0d want 638", a_px[0]); else pass_cnt++;
  endtask

  task automatic test_busy;
    b_rand = 8'd5; b_inicio = 1; @(negedge clk); b_inicio = 0;
    repeat (2) @(negedge clk);
    total_cnt++; if (b_act !== 2'b01 || b_px[0] !== 10'd639 || b_rr !== 1'b1) $display("FAIL busy_start got act=%b x=%0d rr=%b want 01/639/1", b_act, b_px[0], b_rr); else pass_cnt++;
    b_ticks(39);
    total_cnt++; if (b_act !== 2'b11 || b_px[0] !== 10'd600 || b_px[1] !== 10'd639) $display("FAIL busy_second got act=%b x=%0d/%0d want 11/600/639", b_act, b_px[0], b_px[1]); else pass_cnt++;
    b_ticks(39);
    total_cnt++; if (b_act !== 2'b11 || b_px[0] !== 10'd561 || b_px[1] !== 10'd600 || b_rr !== 1'b0) $display("FAIL busy_no_load got act=%b x=%0d/%0d rr=%b want 11/561/600/0", b_act, b_px[0], b_px[1], b_rr); else pass_cnt++;
    b_ticks(561);
    total_cnt++; if (b_act !== 2'b11 || b_px[0] !== 10'd0) $display("FAIL busy_wait got act=%b x=%0d want 11/0", b_act, b_px[0]); else pass_cnt++;
    b_rand = 8'd200; b_tick = 1; @(negedge clk); b_tick = 0;
    total_cnt++; if (b_act !== 2'b10 || b_rr !== 1'b0) $display("FAIL busy_free got act=%b rr=%b want 10/0", b_act, b_rr); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (b_act !== 2'b11 || b_px[0] !== 10'd639 || b_rr !== 1'b1) $display("FAIL busy_deferred got act=%b x=%0d rr=%b want 11/639/1", b_act, b_px[0], b_rr); else pass_cnt++;
    total_cnt++; if (b_gy[0] !== 9'd264 || b_px[1] !== 10'd38) $display("FAIL busy_values got gap=%0d x1=%0d want 264/38", b_gy[0], b_px[1]); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    #2 rst_n = 0;
    #1;
    total_cnt++; if ({a_rr, a_sp, a_run, a_go} !== 4'b0 || a_act !== 3'b000) $display("FAIL rst_mid_flags got %b act=%b want 0000/000", {a_rr, a_sp, a_run, a_go}, a_act); else pass_cnt++;
    total_cnt++; if (a_posx !== 30'd0 || a_gap !== 27'd0 || b_act !== 2'b00) $display("FAIL rst_mid_pos got %h/%h/%b want 0/0/00", a_posx, a_gap, b_act); else pass_cnt++;
    @(negedge clk); rst_n = 1;
    a_ticks(2);
    total_cnt++; if (a_act !== 3'b000 || a_run !== 1'b0) $display("FAIL rst_mid_idle got act=%b run=%b want 000/0", a_act, a_run); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_scroll();
    test_score();
    test_collision();
    test_pause();
    test_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
